// File: rtl/axi4_ddr_slave_model_if.sv
// AXI4 bus bundle between a DMA master and the memory-backed slave model.
// AxSIZE/AxBURST are left out because the slave treats every burst as full-width INCR.
interface axi_inf #(
    parameter int ASIZE  = 32,
    parameter int DSIZE  = 128,
    parameter int IDSIZE = 4,
    parameter int LSIZE  = 8
);
    logic [IDSIZE-1:0]  awid;
    logic [ASIZE-1:0]   awaddr;
    logic [LSIZE-1:0]   awlen;
    logic               awvalid;
    logic               awready;
    logic [DSIZE-1:0]   wdata;
    logic [DSIZE/8-1:0] wstrb;
    logic               wlast;
    logic               wvalid;
    logic               wready;
    logic [IDSIZE-1:0]  bid;
    logic [1:0]         bresp;
    logic               bvalid;
    logic               bready;
    logic [IDSIZE-1:0]  arid;
    logic [ASIZE-1:0]   araddr;
    logic [LSIZE-1:0]   arlen;
    logic               arvalid;
    logic               arready;
    logic [IDSIZE-1:0]  rid;
    logic [DSIZE-1:0]   rdata;
    logic [1:0]         rresp;
    logic               rlast;
    logic               rvalid;
    logic               rready;

    modport master (
        output awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
               arid, araddr, arlen, arvalid, rready,
        input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );
    modport slave (
        input  awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
               arid, araddr, arlen, arvalid, rready,
        output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi4_ddr_slave_model.sv
// AXI4 slave backed by an on-chip word memory; independent write and read engines, one burst each.
// Optional AXI4_SLAVE_RANGE_CHECK_EN: beats whose word index reaches DEPTH are dropped/zeroed with DECERR.
module axi4_ddr_slave_model #(
    parameter int ASIZE  = 32,
    parameter int DSIZE  = 128,
    parameter int IDSIZE = 4,
    parameter int LSIZE  = 8,
    parameter int DEPTH  = 1024
) (
    input  logic   clock,
    input  logic   rst,
    axi_inf.slave  s_axi
);
    localparam int NB = DSIZE / 8;
    localparam int LB = $clog2(NB);
    localparam int IW = ASIZE - LB;
    localparam int DW = $clog2(DEPTH);
    localparam logic [IW-1:0] DEPTH_W = IW'(DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wst_e;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rst_e;

    logic [DSIZE-1:0] mem [DEPTH];
    logic [DSIZE-1:0] rd_q;

    // Holds the ready outputs low for the first cycle out of reset.
    logic alive_q;

    wst_e              w_state_q, w_state_d;
    logic [IDSIZE-1:0] awid_q, awid_d;
    logic [IW-1:0]     wbase_q, wbase_d;
    logic [LSIZE-1:0]  awlen_q, awlen_d;
    logic [LSIZE-1:0]  wcnt_q, wcnt_d;
    logic              werr_q, werr_d;
    logic              wdec_q, wdec_d;

    rst_e              r_state_q, r_state_d;
    logic [IDSIZE-1:0] arid_q, arid_d;
    logic [IW-1:0]     rbase_q, rbase_d;
    logic [LSIZE-1:0]  arlen_q, arlen_d;
    logic [LSIZE-1:0]  rcnt_q, rcnt_d;
    logic              rdec_q, rdec_d;

    logic [IW-1:0] widx, ridx;
    logic          w_last, w_oor, we;
    logic          r_last, r_oor, re;

    assign widx   = wbase_q + IW'(wcnt_q);
    assign ridx   = rbase_q + IW'(rcnt_q);
    assign w_last = (wcnt_q == awlen_q);
    assign r_last = (rcnt_q == arlen_q);
`ifdef AXI4_SLAVE_RANGE_CHECK_EN
    assign w_oor = (widx >= DEPTH_W);
    assign r_oor = (ridx >= DEPTH_W);
`else
    assign w_oor = 1'b0;
    assign r_oor = 1'b0;
`endif
    assign we = (w_state_q == W_DATA) && s_axi.wvalid && !w_oor;

    assign s_axi.bid = awid_q;
    assign s_axi.rid = arid_q;

    logic unused_ok;
    assign unused_ok = ^{s_axi.awaddr[LB-1:0], s_axi.araddr[LB-1:0],
                         widx[IW-1:DW], ridx[IW-1:DW], DEPTH_W};

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            alive_q   <= 1'b0;
            w_state_q <= W_IDLE;
            awid_q    <= '0;
            wbase_q   <= '0;
            awlen_q   <= '0;
            wcnt_q    <= '0;
            werr_q    <= 1'b0;
            wdec_q    <= 1'b0;
            r_state_q <= R_IDLE;
            arid_q    <= '0;
            rbase_q   <= '0;
            arlen_q   <= '0;
            rcnt_q    <= '0;
            rdec_q    <= 1'b0;
        end else begin
            alive_q   <= 1'b1;
            w_state_q <= w_state_d;
            awid_q    <= awid_d;
            wbase_q   <= wbase_d;
            awlen_q   <= awlen_d;
            wcnt_q    <= wcnt_d;
            werr_q    <= werr_d;
            wdec_q    <= wdec_d;
            r_state_q <= r_state_d;
            arid_q    <= arid_d;
            rbase_q   <= rbase_d;
            arlen_q   <= arlen_d;
            rcnt_q    <= rcnt_d;
            rdec_q    <= rdec_d;
        end
    end

    // Memory is never reset; the non-blocking read gives read-first behaviour on collisions.
    always_ff @(posedge clock) begin
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (s_axi.wstrb[b]) mem[widx[DW-1:0]][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
            end
        end
        if (re) rd_q <= mem[ridx[DW-1:0]];
    end

    always_comb begin
        w_state_d      = w_state_q;
        awid_d         = awid_q;
        wbase_d        = wbase_q;
        awlen_d        = awlen_q;
        wcnt_d         = wcnt_q;
        werr_d         = werr_q;
        wdec_d         = wdec_q;
        s_axi.awready  = 1'b0;
        s_axi.wready   = 1'b0;
        s_axi.bvalid   = 1'b0;
        s_axi.bresp    = 2'b00;
        unique case (w_state_q)
            W_IDLE: begin
                s_axi.awready = alive_q;
                if (s_axi.awvalid && alive_q) begin
                    awid_d    = s_axi.awid;
                    wbase_d   = s_axi.awaddr[ASIZE-1:LB];
                    awlen_d   = s_axi.awlen;
                    wcnt_d    = '0;
                    werr_d    = 1'b0;
                    wdec_d    = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                s_axi.wready = 1'b1;
                if (s_axi.wvalid) begin
                    if (s_axi.wlast != w_last) werr_d = 1'b1;
                    if (w_oor) wdec_d = 1'b1;
                    if (w_last) w_state_d = W_RESP;
                    else        wcnt_d    = wcnt_q + 1'b1;
                end
            end
            W_RESP: begin
                s_axi.bvalid = 1'b1;
                s_axi.bresp  = wdec_q ? 2'b11 : (werr_q ? 2'b10 : 2'b00);
                if (s_axi.bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d     = r_state_q;
        arid_d        = arid_q;
        rbase_d       = rbase_q;
        arlen_d       = arlen_q;
        rcnt_d        = rcnt_q;
        rdec_d        = rdec_q;
        re            = 1'b0;
        s_axi.arready = 1'b0;
        s_axi.rvalid  = 1'b0;
        s_axi.rlast   = 1'b0;
        s_axi.rresp   = 2'b00;
        s_axi.rdata   = '0;
        unique case (r_state_q)
            R_IDLE: begin
                s_axi.arready = alive_q;
                if (s_axi.arvalid && alive_q) begin
                    arid_d    = s_axi.arid;
                    rbase_d   = s_axi.araddr[ASIZE-1:LB];
                    arlen_d   = s_axi.arlen;
                    rcnt_d    = '0;
                    r_state_d = R_FETCH;
                end
            end
            R_FETCH: begin
                re        = 1'b1;
                rdec_d    = r_oor;
                r_state_d = R_DATA;
            end
            R_DATA: begin
                s_axi.rvalid = 1'b1;
                s_axi.rlast  = r_last;
                s_axi.rresp  = rdec_q ? 2'b11 : 2'b00;
                s_axi.rdata  = rdec_q ? '0 : rd_q;
                if (s_axi.rready) begin
                    if (r_last) r_state_d = R_IDLE;
                    else begin
                        rcnt_d    = rcnt_q + 1'b1;
                        r_state_d = R_FETCH;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi4_ddr_slave_model.sv
// Bench for axi4_ddr_slave_model: vector table of write/read-back bursts plus hand sequences,
// B/R responses checked by a negedge monitor against expectation queues.
module tb_axi4_ddr_slave_model;
    localparam int ASIZE = 32, DWID = 128, IDSIZE = 4, LSIZE = 8, DEPTH = 1024;
    localparam int NB = DWID / 8, LB = $clog2(NB), IW = ASIZE - LB;
`ifdef AXI4_SLAVE_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    typedef struct packed { logic [IDSIZE-1:0] id; logic [1:0] resp; } bexp_t;
    typedef struct packed { logic [IDSIZE-1:0] id; logic [DWID-1:0] data; logic [1:0] resp; logic last; } rexp_t;
    typedef struct {
        logic [ASIZE-1:0] addr;
        logic [LSIZE-1:0] len;
        logic [DWID-1:0]  base;
        logic [NB-1:0]    strb;
        bit               bad;
        bit               tog;
    } vec_t;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    axi_inf #(.ASIZE(ASIZE), .DSIZE(DWID), .IDSIZE(IDSIZE), .LSIZE(LSIZE)) axi ();

    axi4_ddr_slave_model #(.ASIZE(ASIZE), .DSIZE(DWID), .IDSIZE(IDSIZE), .LSIZE(LSIZE), .DEPTH(DEPTH))
        dut (.clock(clock), .rst(rst), .s_axi(axi));

    always #5 clock = ~clock;

    int n_cmp = 0, n_err = 0;
    bexp_t exp_b[$];
    rexp_t exp_r[$];
    logic [DWID-1:0] mdl [int];
    logic [IDSIZE-1:0] id_ctr = '0;
    vec_t vecs [7];

    task automatic chk(input string nm, input logic [DWID-1:0] act, input logic [DWID-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [DWID-1:0] mdl_rd(input int k);
        return mdl.exists(k) ? mdl[k] : '0;
    endfunction

    task automatic mdl_wr(input int wi, input logic [DWID-1:0] d, input logic [NB-1:0] s);
        logic [DWID-1:0] w;
        if (RC && wi >= DEPTH) return;
        w = mdl_rd(wi % DEPTH);
        for (int b = 0; b < NB; b++) if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
        mdl[wi % DEPTH] = w;
    endtask

    // Waits on negedges (bounded) for a ready/valid output; sel 0=awready 1=wready 2=arready.
    task automatic wait_sig(input int sel, input string nm);
        int n = 0;
        logic s;
        do begin
            @(negedge clock);
            n++;
            s = (sel == 0) ? axi.awready : (sel == 1) ? axi.wready : axi.arready;
        end while (!s && n < 50);
        chk(nm, s, 1);
    endtask

    task automatic drain_b(input string nm);
        int n = 0;
        while (exp_b.size() != 0 && n < 100) begin @(negedge clock); n++; end
        chk(nm, exp_b.size(), 0);
    endtask

    task automatic drain_r(input string nm, input bit tog);
        int n = 0;
        while (exp_r.size() != 0 && n < 200) begin
            if (tog) begin @(posedge clock); #1 axi.rready = ~axi.rready; end
            @(negedge clock);
            n++;
        end
        chk(nm, exp_r.size(), 0);
        axi.rready = 1'b1;
    endtask

    task automatic send_aw(input logic [IDSIZE-1:0] id, input logic [ASIZE-1:0] addr, input logic [LSIZE-1:0] len);
        @(posedge clock); #1;
        axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awvalid = 1'b1;
        wait_sig(0, "aw_ready");
        @(posedge clock); #1 axi.awvalid = 1'b0;
    endtask

    // Drives one beat starting just after a posedge; returns just after the accepting posedge.
    task automatic send_beat(input int wi, input logic [DWID-1:0] d, input logic [NB-1:0] s, input logic last);
        axi.wdata = d; axi.wstrb = s; axi.wlast = last; axi.wvalid = 1'b1;
        wait_sig(1, "w_ready");
        mdl_wr(wi, d, s);
        @(posedge clock); #1 axi.wvalid = 1'b0;
    endtask

    task automatic do_write(input logic [ASIZE-1:0] addr, input logic [LSIZE-1:0] len, input logic [DWID-1:0] base,
                            input logic [NB-1:0] strb, input bit bad, input int hold);
        logic [IDSIZE-1:0] id;
        int bi;
        bit dec = 1'b0;
        id = id_ctr; id_ctr++;
        bi = int'(addr[ASIZE-1:LB]);
        for (int i = 0; i <= int'(len); i++) if (RC && bi + i >= DEPTH) dec = 1'b1;
        exp_b.push_back('{id, dec ? 2'b11 : (bad ? 2'b10 : 2'b00)});
        axi.bready = (hold == 0);
        send_aw(id, addr, len);
        for (int i = 0; i <= int'(len); i++)
            send_beat(bi + i, base + DWID'(i), strb, bad ? (i == 0) : (i == int'(len)));
        @(negedge clock);
        chk("b_latency", axi.bvalid, 1);
        for (int k = 1; k < hold; k++) begin
            @(negedge clock);
            chk("b_hold", axi.bvalid, 1);
        end
        if (hold != 0) begin @(posedge clock); #1 axi.bready = 1'b1; end
        drain_b("b_drain");
    endtask

    task automatic do_read(input logic [ASIZE-1:0] addr, input logic [LSIZE-1:0] len, input bit tog);
        logic [IDSIZE-1:0] id;
        int bi, ri;
        id = id_ctr; id_ctr++;
        bi = int'(addr[ASIZE-1:LB]);
        for (int i = 0; i <= int'(len); i++) begin
            ri = bi + i;
            if (RC && ri >= DEPTH) exp_r.push_back('{id, '0, 2'b11, i == int'(len)});
            else                   exp_r.push_back('{id, mdl_rd(ri % DEPTH), 2'b00, i == int'(len)});
        end
        @(posedge clock); #1;
        axi.rready = !tog;
        axi.arid = id; axi.araddr = addr; axi.arlen = len; axi.arvalid = 1'b1;
        wait_sig(2, "ar_ready");
        @(posedge clock); #1 axi.arvalid = 1'b0;
        @(negedge clock);
        chk("r_fetch_gap", axi.rvalid, 0);
        @(negedge clock);
        chk("r_latency", axi.rvalid, 1);
        drain_r("r_drain", tog);
    endtask

    // Scoreboard: stalled responses must already match the head entry; handshakes pop it.
    always @(negedge clock) begin
        if (!rst) begin
            if (axi.bvalid) begin
                if (exp_b.size() == 0) chk("b_unexpected", axi.bvalid, 0);
                else begin
                    chk("bid", axi.bid, exp_b[0].id);
                    chk("bresp", axi.bresp, exp_b[0].resp);
                    if (axi.bready) void'(exp_b.pop_front());
                end
            end
            if (axi.rvalid) begin
                if (exp_r.size() == 0) chk("r_unexpected", axi.rvalid, 0);
                else begin
                    chk("rid", axi.rid, exp_r[0].id);
                    chk("rdata", axi.rdata, exp_r[0].data);
                    chk("rresp", axi.rresp, exp_r[0].resp);
                    chk("rlast", axi.rlast, exp_r[0].last);
                    if (axi.rready) void'(exp_r.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{32'h0000_0100, 8'd3, 128'd1,  {NB{1'b1}}, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_0200, 8'd0, '1,      {NB{1'b1}}, 1'b0, 1'b0};
        vecs[2] = '{32'h0000_0200, 8'd0, '0,      16'h0001,   1'b0, 1'b0};
        vecs[3] = '{32'h0000_3FF0, 8'd0, {4{32'hDEAD_BEEF}}, {NB{1'b1}}, 1'b0, 1'b1};
        vecs[4] = '{32'h0000_3FE0, 8'd3, {4{32'h1111_0000}}, {NB{1'b1}}, 1'b0, 1'b1};
        vecs[5] = '{32'h0000_1234, 8'd7, {4{32'h0BAD_F00D}}, 16'hA5C3,   1'b0, 1'b0};
        vecs[6] = '{32'h0000_0300, 8'd1, 128'h77, {NB{1'b1}}, 1'b1, 1'b0};

        axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awvalid = 1'b0;
        axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b1;
        axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arvalid = 1'b0; axi.rready = 1'b1;

        @(negedge clock);
        chk("rst_awready", axi.awready, 0);
        chk("rst_wready", axi.wready, 0);
        chk("rst_arready", axi.arready, 0);
        chk("rst_bvalid", axi.bvalid, 0);
        chk("rst_rvalid", axi.rvalid, 0);
        chk("rst_bresp", axi.bresp, 0);
        chk("rst_rresp", axi.rresp, 0);
        chk("rst_bid", axi.bid, 0);
        chk("rst_rid", axi.rid, 0);
        chk("rst_rdata", axi.rdata, 0);
        chk("rst_rlast", axi.rlast, 0);
        repeat (2) @(posedge clock);
        #1 rst = 1'b0;

        foreach (vecs[v]) begin
            if (v == 6) do_write(vecs[v].addr, vecs[v].len, vecs[v].base, vecs[v].strb, vecs[v].bad, 5);
            else        do_write(vecs[v].addr, vecs[v].len, vecs[v].base, vecs[v].strb, vecs[v].bad, 0);
            do_read(vecs[v].addr, vecs[v].len, vecs[v].tog);
        end

        // Reset in the middle of an 8-beat write after three accepted beats.
        send_aw(id_ctr, 32'h0000_0800, 8'd7);
        id_ctr++;
        for (int i = 0; i < 3; i++) send_beat(32'h80 + i, 128'hC0DE_0000 + DWID'(i), {NB{1'b1}}, 1'b0);
        rst = 1'b1;
        @(negedge clock);
        chk("mid_rst_awready", axi.awready, 0);
        chk("mid_rst_wready", axi.wready, 0);
        chk("mid_rst_bvalid", axi.bvalid, 0);
        chk("mid_rst_rvalid", axi.rvalid, 0);
        @(posedge clock); #1 rst = 1'b0;
        repeat (4) begin
            @(negedge clock);
            chk("no_b_after_rst", axi.bvalid, 0);
        end
        do_read(32'h0000_0800, 8'd2, 1'b0);
        do_write(32'h0000_0900, 8'd1, 128'h4242, {NB{1'b1}}, 1'b0, 0);
        do_read(32'h0000_0900, 8'd1, 1'b0);

        // Word 0 against a write one word past the end of memory.
        do_write(32'h0000_0000, 8'd0, {4{32'hA5A5_A5A5}}, {NB{1'b1}}, 1'b0, 0);
        do_write(DEPTH * NB, 8'd0, {4{32'h5A5A_5A5A}}, {NB{1'b1}}, 1'b0, 0);
        do_read(32'h0000_0000, 8'd0, 1'b0);
        do_read(DEPTH * NB, 8'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
